// File: rtl/wb_victim_cache_ctrl.sv
// Fully associative, exclusive victim cache for the write-back dcache.
// Evicted dcache lines are parked here and handed back on a dcache miss. Dirty lines
// displaced by round-robin replacement, or swept by a flush, are written back to memory.
module wb_victim_cache_ctrl #(
    parameter int unsigned VC_ENTRIES  = 4,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned LADDR_WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lookup_req_i,
    input  logic [LADDR_WIDTH-1:0] lookup_laddr_i,
    output logic                   lookup_hit_o,
    output logic [LINE_WIDTH-1:0]  lookup_data_o,
    output logic                   lookup_dirty_o,
    input  logic                   insert_req_i,
    input  logic [LADDR_WIDTH-1:0] insert_laddr_i,
    input  logic [LINE_WIDTH-1:0]  insert_data_i,
    input  logic                   insert_dirty_i,
    output logic                   insert_ready_o,
    output logic                   vc2mem_req_o,
    output logic [LADDR_WIDTH-1:0] vc2mem_laddr_o,
    output logic [LINE_WIDTH-1:0]  vc2mem_data_o,
    input  logic                   mem2vc_ack_i,
    input  logic                   flush_i,
    output logic                   flush_done_o
);

    localparam int unsigned IW = $clog2(VC_ENTRIES);

    typedef enum logic [1:0] {StIdle, StWrb, StFlush, StFlushWb} state_e;

    state_e                  r_state;
    logic [VC_ENTRIES-1:0]   r_valid;
    logic [VC_ENTRIES-1:0]   r_dirty;
    logic [LADDR_WIDTH-1:0]  r_laddr [VC_ENTRIES];
    logic [LINE_WIDTH-1:0]   r_data  [VC_ENTRIES];
    logic [IW-1:0]           r_rr_ptr;
    logic [IW-1:0]           r_fidx;
    logic                    r_lookup_hit;
    logic                    r_lookup_dirty;
    logic [LINE_WIDTH-1:0]   r_lookup_data;
    logic                    r_req;
    logic [LADDR_WIDTH-1:0]  r_wb_laddr;
    logic [LINE_WIDTH-1:0]   r_wb_data;
    logic                    r_flush_done;

    logic                    w_lookup_en;
    logic                    w_hit;
    logic [IW-1:0]           w_hit_idx;
    logic                    w_match;
    logic [IW-1:0]           w_match_idx;
    logic                    w_free;
    logic [IW-1:0]           w_free_idx;
    logic [IW-1:0]           w_slot;
    logic                    w_use_rr;
    logic                    w_rr_blocked;
    logic                    w_insert_ready;
    logic                    w_flush_step;

    assign w_lookup_en = lookup_req_i && ((r_state == StIdle) || (r_state == StWrb));

    // Tag compare for lookup and insert, then insert slot selection in priority order.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_idx   = '0;
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        // Descending scan so the lowest matching index is the one kept.
        for (int i = int'(VC_ENTRIES) - 1; i >= 0; i--) begin
            if (w_lookup_en && r_valid[i] && (r_laddr[i] == lookup_laddr_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (r_valid[i] && (r_laddr[i] == insert_laddr_i)) begin
                w_match     = 1'b1;
                w_match_idx = IW'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
        end
        w_use_rr = 1'b0;
        if (w_match) begin
            w_slot = w_match_idx;
        end else if (w_free) begin
            w_slot = w_free_idx;
        end else if (w_hit) begin
            w_slot = w_hit_idx;
        end else begin
            w_slot   = r_rr_ptr;
            w_use_rr = 1'b1;
        end
        w_rr_blocked   = w_use_rr && r_dirty[r_rr_ptr];
        w_insert_ready = (r_state == StIdle) && !w_rr_blocked;
        w_flush_step   = ((r_state == StFlush) && !(r_valid[r_fidx] && r_dirty[r_fidx])) ||
                         ((r_state == StFlushWb) && mem2vc_ack_i);
    end

    // Entry array, lookup response registers and the writeback/flush FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_valid        <= '0;
            r_dirty        <= '0;
            r_rr_ptr       <= '0;
            r_fidx         <= '0;
            r_lookup_hit   <= 1'b0;
            r_lookup_dirty <= 1'b0;
            r_lookup_data  <= '0;
            r_req          <= 1'b0;
            r_wb_laddr     <= '0;
            r_wb_data      <= '0;
            r_flush_done   <= 1'b0;
        end else begin
            r_flush_done   <= 1'b0;
            r_lookup_hit   <= w_hit;
            r_lookup_data  <= w_hit ? r_data[w_hit_idx] : '0;
            r_lookup_dirty <= w_hit && r_dirty[w_hit_idx];
            // Exclusive: a hit line leaves the victim cache.
            if (w_hit) begin
                r_valid[w_hit_idx] <= 1'b0;
            end
            // Written after the invalidation so a swap into the hit slot wins.
            if (insert_req_i && w_insert_ready) begin
                r_valid[w_slot] <= 1'b1;
                r_laddr[w_slot] <= insert_laddr_i;
                r_data[w_slot]  <= insert_data_i;
                r_dirty[w_slot] <= insert_dirty_i | (w_match & r_dirty[w_slot]);
                if (w_use_rr) begin
                    r_rr_ptr <= IW'(r_rr_ptr + 1);
                end
            end
            case (r_state)
                StIdle: begin
                    if (flush_i) begin
                        r_state <= StFlush;
                        r_fidx  <= '0;
                    end else if (insert_req_i && w_rr_blocked) begin
                        r_wb_laddr <= r_laddr[r_rr_ptr];
                        r_wb_data  <= r_data[r_rr_ptr];
                        r_req      <= 1'b1;
                        r_state    <= StWrb;
                    end
                end
                StWrb: begin
                    if (mem2vc_ack_i) begin
                        r_req             <= 1'b0;
                        r_dirty[r_rr_ptr] <= 1'b0;
                        r_state           <= StIdle;
                    end
                end
                StFlush: begin
                    if (r_valid[r_fidx] && r_dirty[r_fidx]) begin
                        r_wb_laddr <= r_laddr[r_fidx];
                        r_wb_data  <= r_data[r_fidx];
                        r_req      <= 1'b1;
                        r_state    <= StFlushWb;
                    end
                end
                StFlushWb: begin
                    if (mem2vc_ack_i) begin
                        r_req <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Retire the current flush index: invalidate it and advance or finish.
            if (w_flush_step) begin
                r_valid[r_fidx] <= 1'b0;
                r_dirty[r_fidx] <= 1'b0;
                if (r_fidx == IW'(VC_ENTRIES - 1)) begin
                    r_flush_done <= 1'b1;
                    r_rr_ptr     <= '0;
                    r_state      <= StIdle;
                end else begin
                    r_fidx  <= IW'(r_fidx + 1);
                    r_state <= StFlush;
                end
            end
        end
    end

    assign lookup_hit_o   = r_lookup_hit;
    assign lookup_data_o  = r_lookup_data;
    assign lookup_dirty_o = r_lookup_dirty;
    assign insert_ready_o = w_insert_ready;
    assign vc2mem_req_o   = r_req;
    assign vc2mem_laddr_o = r_wb_laddr;
    assign vc2mem_data_o  = r_wb_data;
    assign flush_done_o   = r_flush_done;

endmodule

// File: tb/tb_wb_victim_cache_ctrl.sv
// Bench for wb_victim_cache_ctrl: cycle vector table, hand-written reset/WRB sequence,
// then random transactions checked against a line-list reference model.
module tb_wb_victim_cache_ctrl;

    localparam int N  = 4;
    localparam int LW = 128;
    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lookup_req_i = 1'b0;
    logic [AW-1:0] lookup_laddr_i = '0;
    logic          lookup_hit_o;
    logic [LW-1:0] lookup_data_o;
    logic          lookup_dirty_o;
    logic          insert_req_i = 1'b0;
    logic [AW-1:0] insert_laddr_i = '0;
    logic [LW-1:0] insert_data_i = '0;
    logic          insert_dirty_i = 1'b0;
    logic          insert_ready_o;
    logic          vc2mem_req_o;
    logic [AW-1:0] vc2mem_laddr_o;
    logic [LW-1:0] vc2mem_data_o;
    logic          mem2vc_ack_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_done_o;

    always #5 clk = ~clk;

    wb_victim_cache_ctrl #(
        .VC_ENTRIES (N),
        .LINE_WIDTH (LW),
        .LADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_req_i  (lookup_req_i),
        .lookup_laddr_i(lookup_laddr_i),
        .lookup_hit_o  (lookup_hit_o),
        .lookup_data_o (lookup_data_o),
        .lookup_dirty_o(lookup_dirty_o),
        .insert_req_i  (insert_req_i),
        .insert_laddr_i(insert_laddr_i),
        .insert_data_i (insert_data_i),
        .insert_dirty_i(insert_dirty_i),
        .insert_ready_o(insert_ready_o),
        .vc2mem_req_o  (vc2mem_req_o),
        .vc2mem_laddr_o(vc2mem_laddr_o),
        .vc2mem_data_o (vc2mem_data_o),
        .mem2vc_ack_i  (mem2vc_ack_i),
        .flush_i       (flush_i),
        .flush_done_o  (flush_done_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain list of lines plus the replacement pointer.
    logic          m_v   [N];
    logic          m_d   [N];
    logic [AW-1:0] m_a   [N];
    logic [LW-1:0] m_dat [N];
    int            m_rr;

    typedef struct {
        logic          lreq;
        logic [AW-1:0] laddr;
        logic          ireq;
        logic [AW-1:0] iaddr;
        logic          idirty;
        logic          ack;
        logic          flush;
        logic          e_ready;
        logic          e_hit;
        logic          e_req;
        logic [AW-1:0] e_wb;
        logic          e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {4{4'hA, a}};
    endfunction

    function automatic vec_t mk(input logic lr, input logic [AW-1:0] la, input logic ir,
                                input logic [AW-1:0] ia, input logic id, input logic ak,
                                input logic fl, input logic er, input logic eh,
                                input logic eq, input logic [AW-1:0] ew, input logic ed);
        vec_t v;
        v.lreq = lr; v.laddr = la; v.ireq = ir; v.iaddr = ia; v.idirty = id;
        v.ack = ak; v.flush = fl; v.e_ready = er; v.e_hit = eh; v.e_req = eq;
        v.e_wb = ew; v.e_done = ed;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic lr, input logic [AW-1:0] la, input logic ir,
                         input logic [AW-1:0] ia, input logic id, input logic ak,
                         input logic fl);
        lookup_req_i   = lr;
        lookup_laddr_i = la;
        insert_req_i   = ir;
        insert_laddr_i = ia;
        insert_data_i  = line_of(ia);
        insert_dirty_i = id;
        mem2vc_ack_i   = ak;
        flush_i        = fl;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 1'b0;
            m_a[i] = '0;
            m_dat[i] = '0;
        end
        m_rr = 0;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic r_lookup(input logic [AW-1:0] la);
        int h = -1;
        for (int i = 0; i < N; i++) if (m_v[i] && m_a[i] == la) h = i;
        lookup_req_i   = 1'b1;
        lookup_laddr_i = la;
        step();
        lookup_req_i = 1'b0;
        chk1("rnd lookup hit", lookup_hit_o, h >= 0);
        chkw("rnd lookup data", lookup_data_o, (h >= 0) ? m_dat[h] : '0);
        chk1("rnd lookup dirty", lookup_dirty_o, (h >= 0) ? m_d[h] : 1'b0);
        if (h >= 0) m_v[h] = 1'b0;
    endtask

    task automatic r_insert(input logic [AW-1:0] la, input logic [LW-1:0] d, input logic dt,
                            input logic lk, input logic [AW-1:0] lla);
        int  h = -1;
        int  mi = -1;
        int  fi = -1;
        int  slot;
        logic use_rr = 1'b0;
        logic blocked;
        logic nd;
        for (int i = N - 1; i >= 0; i--) begin
            if (lk && m_v[i] && m_a[i] == lla) h = i;
            if (m_v[i] && m_a[i] == la) mi = i;
            if (!m_v[i]) fi = i;
        end
        if (mi >= 0) slot = mi;
        else if (fi >= 0) slot = fi;
        else if (h >= 0) slot = h;
        else begin
            slot = m_rr;
            use_rr = 1'b1;
        end
        blocked = use_rr && m_d[m_rr];
        lookup_req_i   = lk;
        lookup_laddr_i = lla;
        insert_req_i   = 1'b1;
        insert_laddr_i = la;
        insert_data_i  = d;
        insert_dirty_i = dt;
        #1;
        chk1("rnd insert ready", insert_ready_o, !blocked);
        if (blocked) begin
            step();
            lookup_req_i = 1'b0;
            chk1("rnd blocked lookup hit", lookup_hit_o, 1'b0);
            chk1("rnd wb req", vc2mem_req_o, 1'b1);
            chka("rnd wb laddr", vc2mem_laddr_o, m_a[m_rr]);
            chkw("rnd wb data", vc2mem_data_o, m_dat[m_rr]);
            repeat ($urandom_range(0, 3)) begin
                step();
                chk1("rnd wb req held", vc2mem_req_o, 1'b1);
                chk1("rnd wb ready low", insert_ready_o, 1'b0);
            end
            mem2vc_ack_i = 1'b1;
            step();
            mem2vc_ack_i = 1'b0;
            chk1("rnd wb req drop", vc2mem_req_o, 1'b0);
            chk1("rnd ready after ack", insert_ready_o, 1'b1);
            m_d[m_rr] = 1'b0;
            step();
            insert_req_i = 1'b0;
            m_v[m_rr] = 1'b1;
            m_a[m_rr] = la;
            m_dat[m_rr] = d;
            m_d[m_rr] = dt;
            m_rr = (m_rr + 1) % N;
        end else begin
            step();
            lookup_req_i = 1'b0;
            insert_req_i = 1'b0;
            chk1("rnd ins lookup hit", lookup_hit_o, h >= 0);
            chkw("rnd ins lookup data", lookup_data_o, (h >= 0) ? m_dat[h] : '0);
            chk1("rnd ins no wb", vc2mem_req_o, 1'b0);
            nd = dt | ((mi >= 0) ? m_d[slot] : 1'b0);
            if (h >= 0) m_v[h] = 1'b0;
            m_v[slot] = 1'b1;
            m_a[slot] = la;
            m_dat[slot] = d;
            m_d[slot] = nd;
            if (use_rr) m_rr = (m_rr + 1) % N;
        end
    endtask

    task automatic r_flush();
        logic [AW-1:0] qa[$];
        logic [LW-1:0] qd[$];
        logic seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_d[i]) begin
                qa.push_back(m_a[i]);
                qd.push_back(m_dat[i]);
            end
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            if (flush_done_o) begin
                seen = 1'b1;
            end else begin
                chk1("flush ready low", insert_ready_o, 1'b0);
                if (vc2mem_req_o) begin
                    if (qa.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL flush extra writeback: got laddr %h expected none",
                                 vc2mem_laddr_o);
                    end else begin
                        chka("flush wb laddr", vc2mem_laddr_o, qa.pop_front());
                        chkw("flush wb data", vc2mem_data_o, qd.pop_front());
                    end
                    mem2vc_ack_i = 1'b1;
                    step();
                    mem2vc_ack_i = 1'b0;
                end else begin
                    step();
                end
            end
        end
        chk1("flush done seen", seen, 1'b1);
        chk1("flush all written back", qa.size() == 0, 1'b1);
        step();
        chk1("flush done pulse", flush_done_o, 1'b0);
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 lr la      ir ia      id ak fl  er eh eq wb      dn
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h10, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h11, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h12, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h13, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h12, 0, 28'h00, 0, 0, 0,  1, 1, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h12, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h12, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h10, 1, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h20, 0, 0, 0,  0, 0, 1, 28'h10, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h20, 0, 0, 0,  0, 0, 1, 28'h10, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h20, 0, 0, 0,  0, 0, 1, 28'h10, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h20, 0, 1, 0,  0, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h20, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h11, 1, 28'h30, 0, 0, 0,  1, 1, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h30, 0, 28'h00, 0, 0, 0,  1, 1, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h31, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h40, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h31, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h12, 0, 28'h00, 0, 0, 0,  1, 1, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h22, 1, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 1, 28'h20, 1, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 1,  0, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 0,  0, 0, 1, 28'h20, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 1, 0,  0, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 0,  0, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 0,  0, 0, 1, 28'h22, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 1, 0,  0, 0, 0, 28'h00, 0));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 0,  0, 0, 0, 28'h00, 1));
        tbl.push_back(mk(0, 28'h00, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h20, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h40, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h22, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));
        tbl.push_back(mk(1, 28'h13, 0, 28'h00, 0, 0, 0,  1, 0, 0, 28'h00, 0));

        do_reset();
        chk1("reset hit", lookup_hit_o, 1'b0);
        chkw("reset data", lookup_data_o, '0);
        chk1("reset req", vc2mem_req_o, 1'b0);
        chk1("reset done", flush_done_o, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].lreq, tbl[i].laddr, tbl[i].ireq, tbl[i].iaddr, tbl[i].idirty,
                  tbl[i].ack, tbl[i].flush);
            #1;
            chk1($sformatf("v%0d ready", i), insert_ready_o, tbl[i].e_ready);
            step();
            chk1($sformatf("v%0d hit", i), lookup_hit_o, tbl[i].e_hit);
            chkw($sformatf("v%0d data", i), lookup_data_o,
                 tbl[i].e_hit ? line_of(tbl[i].laddr) : '0);
            chk1($sformatf("v%0d req", i), vc2mem_req_o, tbl[i].e_req);
            if (tbl[i].e_req) begin
                chka($sformatf("v%0d wb laddr", i), vc2mem_laddr_o, tbl[i].e_wb);
                chkw($sformatf("v%0d wb data", i), vc2mem_data_o, line_of(tbl[i].e_wb));
            end
            chk1($sformatf("v%0d done", i), flush_done_o, tbl[i].e_done);
        end

        // Dirty fill, writeback started, lookup steals the line under writeback, then reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 1, 28'h50 + AW'(i), 1, 0, 0);
            step();
        end
        drive(0, 0, 1, 28'h60, 0, 0, 0);
        step();
        chk1("seq wrb req", vc2mem_req_o, 1'b1);
        chka("seq wrb laddr", vc2mem_laddr_o, 28'h50);
        drive(1, 28'h50, 1, 28'h60, 0, 0, 0);
        step();
        chk1("seq wrb lookup hit", lookup_hit_o, 1'b1);
        chkw("seq wrb lookup data", lookup_data_o, line_of(28'h50));
        chk1("seq wrb lookup dirty", lookup_dirty_o, 1'b1);
        chk1("seq wrb req still held", vc2mem_req_o, 1'b1);
        drive(0, 0, 1, 28'h60, 0, 0, 0);
        rst_n = 1'b0;
        step();
        chk1("seq reset drops req", vc2mem_req_o, 1'b0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk1("seq ready after reset", insert_ready_o, 1'b1);
        step();
        chk1("seq stray ack ignored", vc2mem_req_o, 1'b0);
        drive(1, 28'h51, 0, 0, 0, 0, 0);
        step();
        chk1("seq entries invalid", lookup_hit_o, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0);

        do_reset();
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [AW-1:0] a;
            logic [AW-1:0] b;
            r = int'($urandom_range(0, 99));
            a = 28'h100 + AW'($urandom_range(0, 7));
            b = 28'h100 + AW'($urandom_range(0, 7));
            if (r < 35) r_lookup(a);
            else if (r < 80) r_insert(a, {$urandom, $urandom, $urandom, $urandom},
                                      1'($urandom_range(0, 1)), 1'b0, b);
            else if (r < 94) r_insert(a, {$urandom, $urandom, $urandom, $urandom},
                                      1'($urandom_range(0, 1)), 1'b1, b);
            else r_flush();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
